// File: rtl/frame_header_extract.sv
// Pops a frame descriptor and its bytes, captures DA/SA, runs one lookup, then forwards or drains.
// Optional FLOOD_UNKNOWN_EN: a lookup nak floods to every port except the source.
module frame_header_extract #(
    parameter int MIN_LEN      = 12,
    parameter int LKUP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        ptr_sfifo_rd,
    input  logic [15:0] ptr_sfifo_dout,
    input  logic        ptr_sfifo_empty,
    output logic        sfifo_rd,
    input  logic [7:0]  sfifo_dout,
    output logic        se_req,
    output logic [47:0] se_da,
    output logic [47:0] se_sa,
    output logic [3:0]  se_source,
    input  logic        se_ack,
    input  logic        se_nak,
    input  logic [3:0]  se_portmap,
    input  logic        o_bp,
    output logic        o_data_wr,
    output logic [7:0]  o_data,
    output logic        o_ptr_wr,
    output logic [15:0] o_ptr,
    output logic [15:0] pkt_fwd_cnt,
    output logic [15:0] pkt_drop_cnt
);
    localparam int HDR_LEN = 12;

    typedef enum logic [3:0] {IDLE, PTR_RD, PTR, HDR, LOOKUP, FWD, DRAIN, DONE, GAP} state_t;

    state_t      state;
    logic [10:0] len;
    logic [10:0] cnt;
    logic [3:0]  dest;
    logic [15:0] tmr;
    logic        rd_d;

    logic [95:0] hdr;
    logic [3:0]  hdr_idx;
    logic [7:0]  hdr_byte;
    logic [3:0]  nak_dest;
    logic [3:0]  ack_dest;
    logic [3:0]  lk_dest;
    logic [11:0] rd_ahead;
    logic [10:0] rem_len;
    logic        unused_rsvd;

    assign unused_rsvd = ptr_sfifo_dout[15];

    always_comb begin
`ifdef FLOOD_UNKNOWN_EN
        nak_dest = ~se_source;
`else
        nak_dest = 4'h0;
`endif
        ack_dest = se_nak ? nak_dest : (se_portmap & ~se_source);
        lk_dest  = se_ack ? ack_dest : 4'h0;
        hdr      = {se_da, se_sa};
        hdr_idx  = (cnt < 11'(HDR_LEN)) ? (4'(HDR_LEN - 1) - cnt[3:0]) : 4'h0;
        hdr_byte = hdr[{hdr_idx, 3'b000} +: 8];
        // FIFO read for byte k is issued two cycles before byte k is written out
        rd_ahead = {1'b0, cnt} + 12'd2;
        rem_len  = len - 11'(HDR_LEN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            ptr_sfifo_rd <= 1'b0;
            sfifo_rd     <= 1'b0;
            se_req       <= 1'b0;
            se_da        <= '0;
            se_sa        <= '0;
            se_source    <= '0;
            o_data_wr    <= 1'b0;
            o_data       <= '0;
            o_ptr_wr     <= 1'b0;
            o_ptr        <= '0;
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
            len          <= '0;
            cnt          <= '0;
            dest         <= '0;
            tmr          <= '0;
            rd_d         <= 1'b0;
        end else begin
            rd_d         <= sfifo_rd;
            ptr_sfifo_rd <= 1'b0;
            o_ptr_wr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ptr_sfifo_empty && !o_bp) begin
                        ptr_sfifo_rd <= 1'b1;
                        state        <= PTR_RD;
                    end
                end
                PTR_RD: state <= PTR;
                PTR: begin
                    len       <= ptr_sfifo_dout[10:0];
                    se_source <= ptr_sfifo_dout[14:11];
                    dest      <= 4'h0;
                    if (ptr_sfifo_dout[10:0] == 11'd0) begin
                        state <= DONE;
                    end else if (ptr_sfifo_dout[10:0] < 11'(MIN_LEN)) begin
                        sfifo_rd <= 1'b1;
                        cnt      <= ptr_sfifo_dout[10:0];
                        state    <= DRAIN;
                    end else begin
                        sfifo_rd <= 1'b1;
                        cnt      <= 11'(HDR_LEN);
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (cnt != 11'd0) cnt <= cnt - 11'd1;
                    if (cnt == 11'd1) sfifo_rd <= 1'b0;
                    if (rd_d) {se_da, se_sa} <= {se_da[39:0], se_sa, sfifo_dout};
                    if (rd_d && cnt == 11'd0) begin
                        se_req <= 1'b1;
                        tmr    <= '0;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (se_ack || tmr == 16'(LKUP_TIMEOUT - 1)) begin
                        se_req <= 1'b0;
                        dest   <= lk_dest;
                        if (lk_dest != 4'h0) begin
                            cnt   <= '0;
                            state <= FWD;
                        end else if (rem_len == 11'd0) begin
                            state <= DONE;
                        end else begin
                            sfifo_rd <= 1'b1;
                            cnt      <= rem_len;
                            state    <= DRAIN;
                        end
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                FWD: begin
                    o_data_wr <= 1'b1;
                    o_data    <= (cnt < 11'(HDR_LEN)) ? hdr_byte : sfifo_dout;
                    sfifo_rd  <= (rd_ahead >= 12'(HDR_LEN)) && (rd_ahead < {1'b0, len});
                    if (cnt == len - 11'd1) state <= DONE;
                    else cnt <= cnt + 11'd1;
                end
                DRAIN: begin
                    if (cnt == 11'd1) begin
                        sfifo_rd <= 1'b0;
                        state    <= DONE;
                    end
                    cnt <= cnt - 11'd1;
                end
                DONE: begin
                    o_data_wr <= 1'b0;
                    sfifo_rd  <= 1'b0;
                    if (dest != 4'h0) begin
                        o_ptr_wr    <= 1'b1;
                        o_ptr       <= {1'b0, dest, len};
                        pkt_fwd_cnt <= pkt_fwd_cnt + 16'd1;
                    end else begin
                        pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                    end
                    cnt   <= 11'd1;
                    state <= GAP;
                end
                // two dead cycles keep the egress writer clear of the next descriptor
                GAP: begin
                    if (cnt == 11'd0) state <= IDLE;
                    else cnt <= cnt - 11'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/frame_header_extract.md
# frame_header_extract

Switch-core stage directly downstream of the ingress arbiter. It pops one frame descriptor and its data bytes from the merged ingress FIFOs, and captures the 6-byte destination and 6-byte source MAC. It issues one lookup request to the search engine. The frame is then forwarded to the egress queue writer with a destination portmap, or drained and dropped.

## Interface
- `MIN_LEN`, 12: minimum frame length in bytes; descriptors with a shorter length are dropped.
- `LKUP_TIMEOUT`, 255: cycles to wait for `se_ack` before the frame is dropped.
- `clk`  in  1  core clock
- `rstn`  in  1  asynchronous active-low reset
- `ptr_sfifo_rd`  out  1  descriptor FIFO pop
- `ptr_sfifo_dout`  in  16  descriptor: [15] rsvd, [14:11] one-hot source portmap, [10:0] length in bytes (FCS excluded)
- `ptr_sfifo_empty`  in  1  descriptor FIFO empty
- `sfifo_rd`  out  1  data FIFO pop
- `sfifo_dout`  in  8  frame byte
- `se_req`  out  1  lookup request, level
- `se_da`  out  48  destination MAC, first byte received in [47:40]
- `se_sa`  out  48  source MAC, same byte order
- `se_source`  out  4  source portmap
- `se_ack`  in  1  one-cycle lookup completion
- `se_nak`  in  1  DA unknown; valid with `se_ack`
- `se_portmap`  in  4  destination portmap; valid with `se_ack`
- `o_bp`  in  1  egress backpressure
- `o_data_wr`  out  1  egress data write
- `o_data`  out  8  egress byte
- `o_ptr_wr`  out  1  egress descriptor write
- `o_ptr`  out  16  {1'b0, dest_portmap[3:0], len[10:0]}
- `pkt_fwd_cnt`  out  16  forwarded frames, wraps
- `pkt_drop_cnt`  out  16  dropped frames, wraps

## Operation
- Both input FIFOs are standard mode: `dout` is valid in the cycle after `rd`.
- **IDLE**
  - If `!ptr_sfifo_empty && !o_bp`: pulse `ptr_sfifo_rd` for one cycle, then go to PTR.
  - `o_bp` is sampled only in IDLE. Low `o_bp` guarantees room for one 1536-byte frame plus one descriptor.
- **PTR**: latch the length and source portmap.
  - len == 0: go to DONE with drop.
  - 0 < len < `MIN_LEN`: go to DRAIN with drop.
  - Otherwise go to HDR.
- **HDR**: assert `sfifo_rd` for exactly 12 cycles. Shift the 12 returned bytes into the DA/SA register. Then go to LOOKUP.
- **LOOKUP**
  - Hold `se_req` and stable `se_da`/`se_sa`/`se_source` until `se_ack` is sampled high.
  - Deassert `se_req` in the cycle after the ack.
  - dest = `se_portmap & ~source`. With `se_nak` see Configuration.
  - If no ack arrives within `LKUP_TIMEOUT` cycles, dest = 0.
  - A nonzero dest goes to FWD. Zero goes to DRAIN with drop.
- **FWD**
  - Emit the 12 header bytes from the register on `o_data_wr`/`o_data`, one per cycle.
  - Then stream bytes 12..len-1: `sfifo_rd` for len-12 cycles, each byte written out one cycle after it returns.
  - Go to DONE.
- **DRAIN**: pop the remaining bytes (len-12, or len for short frames) with `o_data_wr` held low. Go to DONE.
- **DONE**
  - Forward: pulse `o_ptr_wr` with `o_ptr` = {0, dest, len}, increment `pkt_fwd_cnt`.
  - Drop: increment `pkt_drop_cnt`.
  - Return to IDLE.
- `sfifo_rd` is asserted for exactly len cycles per descriptor on every path. A drop never desynchronises the two FIFOs.
- `se_ack` outside LOOKUP is ignored.

## Timing
- Reset value of every output is 0: `ptr_sfifo_rd`, `sfifo_rd`, `se_req`, `se_da`, `se_sa`, `se_source`, `o_data_wr`, `o_data`, `o_ptr_wr`, `o_ptr`, both counters. FSM resets to IDLE.
- Reset mid-frame aborts immediately. Upstream FIFOs are reset by the same `rstn`.
- All outputs are registered.
- `o_ptr_wr` is always at least 1 cycle after the last `o_data_wr` of the same frame.
- Lookup handshake: `se_req` rises 1 cycle after the 12th header byte is captured.
- Forwarding, with ack in cycle A:
  - first `o_data_wr` in A+2;
  - `o_data_wr` is continuous for len cycles;
  - `o_ptr_wr` in A+2+len.
- Back-to-back frames: at least 2 idle cycles between `o_ptr_wr` and the next `ptr_sfifo_rd`.
- Counters wrap from 16'hFFFF to 0.

## Configuration
- `FLOOD_UNKNOWN_EN`
  - Defined: `se_nak` gives dest = 4'b1111 & ~source (flood).
  - Undefined: `se_nak` gives dest = 0, so the frame is drained and `pkt_drop_cnt` increments.
  - Timeout drops the frame in both builds.

## Test plan
- 64-byte frame, source 4'b0001, `se_portmap` 4'b0100 acked after 3 cycles -> 64 `o_data_wr` bytes matching the input, then `o_ptr` = 16'h2040; `pkt_fwd_cnt` = 1.
- Lookup returns the source port only (portmap 4'b0001, source 4'b0001) -> no `o_data_wr`; 64 `sfifo_rd`; `pkt_drop_cnt` = 1. A following 60-byte frame forwards with intact data.
- `se_nak` for a frame from port 2 (4'b0100):
  - Build with `FLOOD_UNKNOWN_EN` -> dest 4'b1011.
  - Build without it -> drop.
- Descriptor len 8 then len 0 -> 8 `sfifo_rd` and 0 `sfifo_rd` respectively; `pkt_drop_cnt` = 2; no `se_req`.
- `se_ack` withheld 300 cycles -> `se_req` drops after 255 cycles, frame drained, `pkt_drop_cnt` increments; a late `se_ack` is ignored.
- `o_bp` high with descriptors pending -> no `ptr_sfifo_rd`. Release `o_bp` -> pop in the next cycle. Assert `rstn` low mid-FWD -> all outputs 0 and FSM in IDLE.
